// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: forwarding selects, load-use/branch stalls, redirect gating and MUL/DIV EX hold.
// Define HAZ_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_ctrl_param #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rt_i,
  input  logic                  id_branch_i,
  input  logic                  id_redirect_i,
  input  logic                  id_mc_i,
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_regwrite_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_regwrite_i,
  input  logic                  mem_memread_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  output logic                  pc_en_o,
  output logic                  ifid_en_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  ex_hold_o,
  output logic                  redirect_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [1:0]            fwd_id_a_o,
  output logic [1:0]            fwd_id_b_o,
  output logic                  mc_busy_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);
  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy, stall_lu, stall_br, stall, accept;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src, input logic mem_w,
                                         input logic [REG_ADDR_W-1:0] mem_rd, input logic wb_w,
                                         input logic [REG_ADDR_W-1:0] wb_rd);
    return (mem_w && mem_rd != '0 && mem_rd == src) ? 2'b01 :
           (wb_w && wb_rd != '0 && wb_rd == src)    ? 2'b10 : 2'b00;
  endfunction

  function automatic logic id_match(input logic [REG_ADDR_W-1:0] rd, input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rt, input logic use_rs, input logic use_rt);
    return rd != '0 && ((use_rs && rd == rs) || (use_rt && rd == rt));
  endfunction

  assign busy     = state_q == BUSY;
  assign stall_lu = ex_memread_i && id_match(ex_rd_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i);
  assign stall_br = id_branch_i &&
                    ((ex_regwrite_i && id_match(ex_rd_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i)) ||
                     (mem_memread_i && id_match(mem_rd_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i)));
  assign stall    = stall_lu | stall_br;
  assign accept   = ~busy & ~stall & id_mc_i & (MC_LAT > 1);

  assign mc_busy_o     = rst_n & busy;
  assign ex_hold_o     = mc_busy_o;
  assign redirect_o    = rst_n & id_redirect_i & ~stall & ~busy;
  assign ifid_flush_o  = ~rst_n | redirect_o;
  assign pc_en_o       = rst_n & ~busy & ~stall;
  assign ifid_en_o     = pc_en_o;
  assign idex_bubble_o = ~rst_n | (~busy & stall);
  // ID comparator cannot take load data from MEM; such cases stall instead
  assign fwd_a_o    = rst_n ? fwd_sel(ex_rs_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i) : 2'b00;
  assign fwd_b_o    = rst_n ? fwd_sel(ex_rt_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i) : 2'b00;
  assign fwd_id_a_o = rst_n ? fwd_sel(id_rs_i, mem_regwrite_i & ~mem_memread_i, mem_rd_i, wb_regwrite_i, wb_rd_i) : 2'b00;
  assign fwd_id_b_o = rst_n ? fwd_sel(id_rt_i, mem_regwrite_i & ~mem_memread_i, mem_rd_i, wb_regwrite_i, wb_rd_i) : 2'b00;

  always_comb begin
    state_d = busy ? ((cnt_q == '0) ? IDLE : BUSY) : (accept ? BUSY : IDLE);
    cnt_d   = accept ? CW'(MC_LAT - 2) : (busy ? cnt_q - 1'b1 : cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall | busy) && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_o && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb_hazard_ctrl_param: directed scenarios then random traffic against a behavioural reference model.
module tb_hazard_ctrl_param;
  localparam int W = 5;
  localparam int LAT = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, id_branch, id_redirect, id_mc;
  logic ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, redirect, mc_busy;
  logic [1:0] fwd_a, fwd_b, fwd_id_a, fwd_id_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int rem = 0;
  int sc = 0;
  int fc = 0;

  always #5 clk = ~clk;

  hazard_ctrl_param #(.REG_ADDR_W(W), .MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .id_branch_i(id_branch), .id_redirect_i(id_redirect), .id_mc_i(id_mc),
    .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .mem_memread_i(mem_memread),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble),
    .ex_hold_o(ex_hold), .redirect_o(redirect),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .fwd_id_a_o(fwd_id_a), .fwd_id_b_o(fwd_id_b),
    .mc_busy_o(mc_busy), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(input logic [W-1:0] rd);
    return rd != 0 && ((id_use_rs && rd == id_rs) || (id_use_rt && rd == id_rt));
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [W-1:0] src, input bit id_side);
    bit mem_ok = mem_regwrite && !(id_side && mem_memread);
    if (mem_ok && mem_rd != 0 && mem_rd == src) return 2'b01;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    rst_n = 1; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_redirect = 0; id_mc = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; mem_memread = 0; wb_rd = 0; wb_regwrite = 0;
  endtask

  // Check every output against the model, then advance the model over one clock edge
  task automatic cyc();
    bit hold, st, rd;
    #1;
    hold = rem > 0;
    st = (ex_memread && reads(ex_rd)) ||
         (id_branch && ((ex_regwrite && reads(ex_rd)) || (mem_memread && reads(mem_rd))));
    rd = rst_n && !hold && !st && id_redirect;
    if (!rst_n) begin
      chk("rst_pc_en", pc_en, 0); chk("rst_ifid_en", ifid_en, 0); chk("rst_flush", ifid_flush, 1);
      chk("rst_bubble", idex_bubble, 1); chk("rst_hold", ex_hold, 0); chk("rst_redirect", redirect, 0);
      chk("rst_busy", mc_busy, 0);
      chk("rst_fwd", {fwd_a, fwd_b, fwd_id_a, fwd_id_b}, 0);
    end else begin
      chk("pc_en", pc_en, !hold && !st);
      chk("ifid_en", ifid_en, !hold && !st);
      chk("bubble", idex_bubble, !hold && st);
      chk("ex_hold", ex_hold, hold);
      chk("mc_busy", mc_busy, hold);
      chk("redirect", redirect, rd);
      chk("ifid_flush", ifid_flush, rd);
      chk("fwd_a", fwd_a, ref_fwd(ex_rs, 0));
      chk("fwd_b", fwd_b, ref_fwd(ex_rt, 0));
      chk("fwd_id_a", fwd_id_a, ref_fwd(id_rs, 1));
      chk("fwd_id_b", fwd_id_b, ref_fwd(id_rt, 1));
    end
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, sc);
    chk("flush_cnt", flush_cnt, fc);
`else
    chk("stall_cnt", stall_cnt, 0);
    chk("flush_cnt", flush_cnt, 0);
`endif
    @(posedge clk);
    if (!rst_n) begin
      rem = 0; sc = 0; fc = 0;
    end else begin
      if (hold || st) sc = (sc < CMAX) ? sc + 1 : CMAX;
      if (rd) fc = (fc < CMAX) ? fc + 1 : CMAX;
      if (hold) rem--;
      else if (!st && id_mc && LAT > 1) rem = LAT - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    cyc(); cyc();
    idle_inputs();
    cyc();
    // load-use: lw r2 in EX, add reads r2
    ex_memread = 1; ex_regwrite = 1; ex_rd = 2; id_rs = 2; id_use_rs = 1;
    #1; chk("lu_pc_en", pc_en, 0); chk("lu_bubble", idex_bubble, 1); cyc();
    idle_inputs(); wb_rd = 2; wb_regwrite = 1; ex_rs = 2;
    #1; chk("lu_fwd_wb", fwd_a, 2'b10); cyc();
    // MEM beats WB; r0 never forwards
    idle_inputs(); mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1; ex_rs = 5;
    #1; chk("mem_prio", fwd_a, 2'b01); cyc();
    mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
    #1; chk("r0_fwd", fwd_a, 2'b00); cyc();
    // branch operand stall beats redirect
    idle_inputs(); id_branch = 1; id_rs = 3; id_use_rs = 1; ex_rd = 3; ex_regwrite = 1; id_redirect = 1;
    #1; chk("br_stall_redir", redirect, 0); chk("br_stall_flush", ifid_flush, 0); cyc();
    ex_rd = 0; ex_regwrite = 0; mem_rd = 3; mem_regwrite = 1;
    #1; chk("br_fwd_id", fwd_id_a, 2'b01); chk("br_redir", redirect, 1); cyc();
    // branch on a load in MEM stalls
    mem_memread = 1;
    #1; chk("br_mem_load", pc_en, 0); cyc();
    // divide: 3 hold cycles, mid-BUSY jump masked
    idle_inputs(); id_mc = 1; cyc();
    idle_inputs(); id_redirect = 1;
    for (int i = 0; i < LAT - 1; i++) begin
      #1; chk("div_hold", ex_hold, 1); chk("div_mask", redirect, 0); cyc();
    end
    #1; chk("div_done", mc_busy, 0); chk("div_jump", redirect, 1); cyc();
    // reset on second BUSY cycle aborts
    idle_inputs(); id_mc = 1; cyc();
    idle_inputs(); cyc();
    rst_n = 0; cyc();
    rst_n = 1;
    #1; chk("abort_hold", ex_hold, 0); cyc(); cyc();
    // 20 stall cycles saturate a 4-bit counter
    idle_inputs(); ex_memread = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1;
    for (int i = 0; i < 20; i++) cyc();
    idle_inputs(); cyc();
`ifdef HAZ_PERF_CNT_EN
    chk("sat_stall", stall_cnt, CMAX);
`endif
    rst_n = 0; cyc();
    idle_inputs(); cyc();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      id_rs = W'($urandom_range(0, 3)); id_rt = W'($urandom_range(0, 3));
      ex_rs = W'($urandom_range(0, 3)); ex_rt = W'($urandom_range(0, 3));
      ex_rd = W'($urandom_range(0, 3)); mem_rd = W'($urandom_range(0, 3)); wb_rd = W'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); id_branch = 1'($urandom);
      id_redirect = 1'($urandom); id_mc = ($urandom_range(0, 5) == 0);
      ex_regwrite = 1'($urandom); ex_memread = ($urandom_range(0, 3) == 0);
      mem_regwrite = 1'($urandom); mem_memread = ($urandom_range(0, 3) == 0); wb_regwrite = 1'($urandom);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
